// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port scheduler in front of a dual-write-port register file.
// Issues up to two non-conflicting register writes per cycle from NumReq requesters.
module regfile_write_arbiter #(
    parameter int NumReq    = 3,
    parameter int AddrWidth = 5,
    parameter int DataWidth = 32
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [NumReq-1:0]             ReqValid,
    output logic [NumReq-1:0]             ReqReady,
    input  logic [NumReq*AddrWidth-1:0]   ReqAddr,
    input  logic [NumReq*DataWidth-1:0]   ReqData,
    output logic [AddrWidth-1:0]          WriteRegister1,
    output logic [AddrWidth-1:0]          WriteRegister2,
    output logic [DataWidth-1:0]          WriteData1,
    output logic [DataWidth-1:0]          WriteData2,
    output logic                          RegWrite1,
    output logic                          RegWrite2,
    output logic [15:0]                   StallCount
);

    localparam int IdxW = $clog2(NumReq);
    localparam int SumW = IdxW + 1;

    logic [AddrWidth-1:0] addr_a [NumReq];
    logic [DataWidth-1:0] data_a [NumReq];

    for (genvar g = 0; g < NumReq; g++) begin : g_unpack
        assign addr_a[g] = ReqAddr[g*AddrWidth +: AddrWidth];
        assign data_a[g] = ReqData[g*DataWidth +: DataWidth];
    end

    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic                 we1_q, we1_d;
    logic                 we2_q, we2_d;
    logic [AddrWidth-1:0] waddr1_q, waddr1_d;
    logic [AddrWidth-1:0] waddr2_q, waddr2_d;
    logic [DataWidth-1:0] wdata1_q, wdata1_d;
    logic [DataWidth-1:0] wdata2_q, wdata2_d;
    logic [15:0]          stall_q, stall_d;

    logic [NumReq-1:0]    ready;
    logic                 grant1;
    logic                 grant2;
    logic [IdxW-1:0]      idx1;
    logic [IdxW-1:0]      idx2;
    logic [IdxW-1:0]      idx;
    logic [SumW-1:0]      sum;
    logic                 stall;

    // Zero-register requests are acknowledged and dropped without taking a port
    // or influencing the pointer; port 2 skips anything aliasing port 1's address.
    always_comb begin
        ready  = '0;
        grant1 = 1'b0;
        grant2 = 1'b0;
        idx1   = '0;
        idx2   = '0;
        idx    = '0;
        sum    = '0;
        if (!Reset) begin
            for (int k = 0; k < NumReq; k++) begin
                sum = {1'b0, ptr_q} + SumW'(k);
                if (sum >= SumW'(NumReq)) begin
                    sum = sum - SumW'(NumReq);
                end
                idx = sum[IdxW-1:0];
                if (ReqValid[idx]) begin
                    if (addr_a[idx] == '0) begin
                        ready[idx] = 1'b1;
                    end else if (!grant1) begin
                        grant1     = 1'b1;
                        idx1       = idx;
                        ready[idx] = 1'b1;
                    end else if (!grant2 && (addr_a[idx] != addr_a[idx1])) begin
                        grant2     = 1'b1;
                        idx2       = idx;
                        ready[idx] = 1'b1;
                    end
                end
            end
        end
    end

    assign stall = !Reset && (|(ReqValid & ~ready));

    always_comb begin
        ptr_d    = ptr_q;
        we1_d    = grant1;
        we2_d    = grant2;
        waddr1_d = '0;
        waddr2_d = '0;
        wdata1_d = '0;
        wdata2_d = '0;
        stall_d  = stall_q;
        if (grant1) begin
            ptr_d    = (idx1 == IdxW'(NumReq - 1)) ? '0 : idx1 + 1'b1;
            waddr1_d = addr_a[idx1];
            wdata1_d = data_a[idx1];
        end
        if (grant2) begin
            waddr2_d = addr_a[idx2];
            wdata2_d = data_a[idx2];
        end
        if (stall && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_q    <= '0;
            we1_q    <= 1'b0;
            we2_q    <= 1'b0;
            waddr1_q <= '0;
            waddr2_q <= '0;
            wdata1_q <= '0;
            wdata2_q <= '0;
            stall_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            we1_q    <= we1_d;
            we2_q    <= we2_d;
            waddr1_q <= waddr1_d;
            waddr2_q <= waddr2_d;
            wdata1_q <= wdata1_d;
            wdata2_q <= wdata2_d;
            stall_q  <= stall_d;
        end
    end

    assign ReqReady       = ready;
    assign RegWrite1      = we1_q;
    assign RegWrite2      = we2_q;
    assign WriteRegister1 = waddr1_q;
    assign WriteRegister2 = waddr2_q;
    assign WriteData1     = wdata1_q;
    assign WriteData2     = wdata2_q;
    assign StallCount     = stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected writes are queued per port
// at acceptance time and popped by a negedge monitor when the DUT presents them.
module tb_regfile_write_arbiter;

    localparam int NR = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            Clk = 1'b0;
    logic            Reset;
    logic [NR-1:0]   ReqValid;
    logic [NR-1:0]   ReqReady;
    logic [NR*AW-1:0] ReqAddr;
    logic [NR*DW-1:0] ReqData;
    logic [AW-1:0]   WriteRegister1;
    logic [AW-1:0]   WriteRegister2;
    logic [DW-1:0]   WriteData1;
    logic [DW-1:0]   WriteData2;
    logic            RegWrite1;
    logic            RegWrite2;
    logic [15:0]     StallCount;

    always #5 Clk = ~Clk;

    regfile_write_arbiter #(.NumReq(NR), .AddrWidth(AW), .DataWidth(DW)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .ReqValid       (ReqValid),
        .ReqReady       (ReqReady),
        .ReqAddr        (ReqAddr),
        .ReqData        (ReqData),
        .WriteRegister1 (WriteRegister1),
        .WriteRegister2 (WriteRegister2),
        .WriteData1     (WriteData1),
        .WriteData2     (WriteData2),
        .RegWrite1      (RegWrite1),
        .RegWrite2      (RegWrite2),
        .StallCount     (StallCount)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t         q1[$];
    wr_t         q2[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_on = 1'b0;
    logic [DW-1:0] rf [32];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    task automatic set_req(input logic [2:0] v,
                           input logic [4:0] a0, input logic [31:0] d0,
                           input logic [4:0] a1, input logic [31:0] d1,
                           input logic [4:0] a2, input logic [31:0] d2);
        ReqValid = v;
        ReqAddr  = {a2, a1, a0};
        ReqData  = {d2, d1, d0};
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic exp_wr(input int port, input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        if (port == 1) q1.push_back(e);
        else           q2.push_back(e);
    endtask

    // Register file model fed by the DUT write ports, used for readback checks.
    always @(posedge Clk) begin
        if (RegWrite1 === 1'b1) rf[WriteRegister1] <= WriteData1;
        if (RegWrite2 === 1'b1) rf[WriteRegister2] <= WriteData2;
    end

    always @(negedge Clk) begin
        wr_t e;
        if (mon_on) begin
            if (RegWrite1 === 1'b1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL port1_unexpected actual=%h/%h required=no write", WriteRegister1, WriteData1);
                end else begin
                    e = q1.pop_front();
                    chk("port1_addr", 32'(WriteRegister1), 32'(e.addr));
                    chk("port1_data", WriteData1, e.data);
                end
            end else begin
                chk("port1_idle_we", 32'(RegWrite1), 32'd0);
                chk("port1_idle_addr", 32'(WriteRegister1), 32'd0);
                chk("port1_idle_data", WriteData1, 32'd0);
            end
            if (RegWrite2 === 1'b1) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL port2_unexpected actual=%h/%h required=no write", WriteRegister2, WriteData2);
                end else begin
                    e = q2.pop_front();
                    chk("port2_addr", 32'(WriteRegister2), 32'(e.addr));
                    chk("port2_data", WriteData2, e.data);
                end
            end else begin
                chk("port2_idle_we", 32'(RegWrite2), 32'd0);
                chk("port2_idle_addr", 32'(WriteRegister2), 32'd0);
                chk("port2_idle_data", WriteData2, 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=still running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] exp_r;
        Reset = 1'b1;
        set_req(3'b111, 5'd1, 32'h1, 5'd2, 32'h2, 5'd0, 32'h3);
        #1;
        chk("reset_ready", 32'(ReqReady), 32'd0);
        step();
        mon_on = 1'b1;
        step();
        chk("reset_ready_2", 32'(ReqReady), 32'd0);
        chk("reset_we1", 32'(RegWrite1), 32'd0);
        chk("reset_we2", 32'(RegWrite2), 32'd0);
        chk("reset_addr1", 32'(WriteRegister1), 32'd0);
        chk("reset_addr2", 32'(WriteRegister2), 32'd0);
        chk("reset_data1", WriteData1, 32'd0);
        chk("reset_data2", WriteData2, 32'd0);
        chk("reset_stall", 32'(StallCount), 32'd0);

        Reset = 1'b0;
        set_req(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        step();

        // Two distinct writes from ptr 0
        set_req(3'b011, 5'd3, 32'hA5A5_0003, 5'd7, 32'h0000_0007, 5'd0, 32'h0);
        #1;
        chk("distinct_ready", 32'(ReqReady), 32'b011);
        exp_wr(1, 5'd3, 32'hA5A5_0003);
        exp_wr(2, 5'd7, 32'h0000_0007);
        step();
        set_req(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        step();
        chk("readback_r3", rf[3], 32'hA5A5_0003);
        chk("readback_r7", rf[7], 32'h0000_0007);

        // ptr is 1: R2 alone moves it back to 0
        set_req(3'b100, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 32'h11);
        #1;
        chk("r2_alone_ready", 32'(ReqReady), 32'b100);
        exp_wr(1, 5'd1, 32'h11);
        step();

        // Address conflict
        set_req(3'b111, 5'd5, 32'h50, 5'd5, 32'h51, 5'd9, 32'h92);
        #1;
        chk("conflict_ready", 32'(ReqReady), 32'b101);
        exp_wr(1, 5'd5, 32'h50);
        exp_wr(2, 5'd9, 32'h92);
        step();
        set_req(3'b010, 5'd5, 32'h50, 5'd5, 32'h51, 5'd9, 32'h92);
        #1;
        chk("conflict_ready_2", 32'(ReqReady), 32'b010);
        chk("conflict_stall", 32'(StallCount), 32'd1);
        exp_wr(1, 5'd5, 32'h51);
        step();
        set_req(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        chk("conflict_stall_hold", 32'(StallCount), 32'd1);

        // Zero-register request alongside two real writes, ptr 2
        set_req(3'b111, 5'd10, 32'hA0, 5'd11, 32'hB1, 5'd0, 32'hDEAD);
        #1;
        chk("zero_ready", 32'(ReqReady), 32'b111);
        exp_wr(1, 5'd10, 32'hA0);
        exp_wr(2, 5'd11, 32'hB1);
        step();

        // Pointer must now be 1 (set from R0, not from the discarded R2)
        set_req(3'b111, 5'd12, 32'hC0, 5'd13, 32'hC1, 5'd14, 32'hC2);
        #1;
        chk("ptr_probe_ready", 32'(ReqReady), 32'b110);
        exp_wr(1, 5'd13, 32'hC1);
        exp_wr(2, 5'd14, 32'hC2);
        step();
        set_req(3'b001, 5'd12, 32'hC0, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        chk("ptr_probe_ready_2", 32'(ReqReady), 32'b001);
        chk("ptr_probe_stall", 32'(StallCount), 32'd2);
        exp_wr(1, 5'd12, 32'hC0);
        step();
        set_req(3'b100, 5'd0, 32'h0, 5'd0, 32'h0, 5'd15, 32'h33);
        #1;
        chk("r2_alone_ready_2", 32'(ReqReady), 32'b100);
        exp_wr(1, 5'd15, 32'h33);
        step();

        // Fairness and stall saturation, ptr 0, all to addr 4
        set_req(3'b111, 5'd4, 32'h4000_0000, 5'd4, 32'h4000_0001, 5'd4, 32'h4000_0002);
        #1;
        for (int i = 0; i < 70000; i++) begin
            exp_r = 3'b001 << (i % 3);
            chk("fair_ready", 32'(ReqReady), 32'(exp_r));
            exp_wr(1, 5'd4, 32'h4000_0000 + 32'(i % 3));
            step();
            if (i == 65531) chk("stall_pre_sat", 32'(StallCount), 32'hFFFE);
            if (i == 65532) chk("stall_sat", 32'(StallCount), 32'hFFFF);
        end
        chk("stall_sat_hold", 32'(StallCount), 32'hFFFF);
        set_req(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        step();
        step();

        // Reset right after an acceptance
        set_req(3'b010, 5'd0, 32'h0, 5'd2, 32'h1234, 5'd0, 32'h0);
        #1;
        chk("midreset_ready", 32'(ReqReady), 32'b010);
        exp_wr(1, 5'd2, 32'h1234);
        step();
        Reset = 1'b1;
        set_req(3'b011, 5'd6, 32'h66, 5'd6, 32'h67, 5'd0, 32'h0);
        #1;
        chk("midreset_ready_rst", 32'(ReqReady), 32'd0);
        step();
        chk("midreset_r2", rf[2], 32'h1234);
        chk("midreset_we1", 32'(RegWrite1), 32'd0);
        chk("midreset_addr1", 32'(WriteRegister1), 32'd0);
        chk("midreset_data1", WriteData1, 32'd0);
        chk("midreset_stall", 32'(StallCount), 32'd0);
        Reset = 1'b0;
        set_req(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        step();
        step();
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
